// File: rtl/seq_scan_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : seq_scan_pkg                                             |
// | Description : Shared constants, depth type and the prefix/suffix       |
// |               fallback function used by the sequence-scan arbiter.     |
// | Contents    : DEF_PAT_W, DEF_PATTERN, MAX_PAT_W, depth_t,              |
// |               prefix_suffix()                                          |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
package seq_scan_pkg;

  localparam int                   DEF_PAT_W   = 4;
  localparam logic [DEF_PAT_W-1:0] DEF_PATTERN = 4'b1101;
  localparam int                   MAX_PAT_W   = 8;

  // Match depth 0..MAX_PAT_W; PAT_W itself only appears transiently
  // to flag a completion.
  typedef logic [3:0] depth_t;

  // Consider the string s = first 'len' pattern bits followed by 'b'.
  // Return the longest k (k <= max_k) such that the first k pattern bits
  // equal the last k bits of s. Pattern bit j (received j-th) lives at
  // pat[pat_w-1-j]. Loop bounds are constant so this unrolls cleanly.
  function automatic depth_t prefix_suffix(
    input logic [MAX_PAT_W-1:0] pat,
    input int                   pat_w,
    input int                   len,
    input logic                 b,
    input int                   max_k
  );
    int                   best;
    int                   si;
    logic                 ok;
    logic                 s_bit;
    logic                 p_bit;
    logic [MAX_PAT_W-1:0] sh;
    best = 0;
    for (int k = 1; k <= MAX_PAT_W; k++) begin
      if (k <= max_k && k <= len + 1) begin
        ok = 1'b1;
        for (int j = 0; j < MAX_PAT_W; j++) begin
          if (j < k) begin
            si    = len + 1 - k + j;
            sh    = pat >> (pat_w - 1 - si);
            s_bit = (si < len) ? sh[0] : b;
            sh    = pat >> (pat_w - 1 - j);
            p_bit = sh[0];
            if (p_bit != s_bit) begin
              ok = 1'b0;
            end
          end
        end
        if (ok) begin
          best = k;
        end
      end
    end
    return depth_t'(best);
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_match_step.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : seq_match_step                                           |
// | Description : Combinational pattern-match step: given the current      |
// |               match depth and one received bit, produce the next      |
// |               depth and a completion flag.                             |
// | Ports       : depth_i      current depth (0..PAT_W-1)                  |
// |               bit_i        received serial bit                         |
// |               next_depth_o depth after consuming bit_i                 |
// |               complete_o   bit_i completed the pattern                 |
// | Config      : SEQ_SCAN_OVERLAP_EN - after a completion, resume at the  |
// |               longest proper prefix-suffix of PATTERN instead of 0.    |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module seq_match_step
  import seq_scan_pkg::*;
#(
  parameter int               PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN
) (
  input  depth_t depth_i,
  input  logic   bit_i,
  output depth_t next_depth_o,
  output logic   complete_o
);

  logic [MAX_PAT_W-1:0] w_pat;
  depth_t               w_adv;
  depth_t               w_after_hit;

  always_comb begin
    w_pat              = '0;
    w_pat[PAT_W-1:0]   = PATTERN;
  end

  always_comb begin
    // A matching bit naturally yields depth+1; a mismatch falls back to
    // the longest prefix still consistent with the received history.
    w_adv = prefix_suffix(w_pat, PAT_W, int'(depth_i), bit_i, PAT_W);
`ifdef SEQ_SCAN_OVERLAP_EN
    // Full pattern just seen: keep its longest proper border.
    w_after_hit = prefix_suffix(w_pat, PAT_W, PAT_W - 1, PATTERN[0], PAT_W - 1);
`else
    w_after_hit = '0;
`endif
    complete_o   = (w_adv == depth_t'(PAT_W));
    next_depth_o = complete_o ? w_after_hit : w_adv;
  end

endmodule
`default_nettype wire

// File: rtl/seq_scan_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : seq_scan_arbiter                                         |
// | Description : Round-robin arbiter over NCH bit-serial channels with    |
// |               one shared pattern matcher; each channel keeps its own   |
// |               match-depth context. Reports completions as a one-cycle  |
// |               hit pulse with channel index and a saturating count.     |
// | Ports       : clk, rst (async, active-high)                            |
// |               ch_valid[NCH], ch_bit[NCH]  channel requests / data      |
// |               ch_ready[NCH]               one-hot grant (comb.)        |
// |               hit, hit_ch, hit_cnt[8]     completion reporting         |
// | Config      : SEQ_SCAN_OVERLAP_EN - overlapping matches (see           |
// |               seq_match_step).                                         |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module seq_scan_arbiter
  import seq_scan_pkg::*;
#(
  parameter int               NCH     = 4,
  parameter int               PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NCH-1:0]          ch_valid,
  input  logic [NCH-1:0]          ch_bit,
  output logic [NCH-1:0]          ch_ready,
  output logic                    hit,
  output logic [$clog2(NCH)-1:0]  hit_ch,
  output logic [7:0]              hit_cnt
);

  localparam int IDX_W = $clog2(NCH);

  depth_t           ctx_q [NCH];
  logic [IDX_W-1:0] ptr_q,     ptr_d;
  logic             hit_q,     hit_d;
  logic [IDX_W-1:0] hit_ch_q,  hit_ch_d;
  logic [7:0]       hit_cnt_q, hit_cnt_d;

  logic             w_gnt_vld;
  logic [IDX_W-1:0] w_gnt_idx;
  logic [NCH-1:0]   w_rot;
  depth_t           w_cur_depth;
  logic             w_cur_bit;
  depth_t           w_next_depth;
  logic             w_complete;

  // Rotate requests so bit 0 is the channel at ptr; the lowest set bit
  // of the rotated vector is then the round-robin winner.
  always_comb begin : p_arb
    int sum;
    sum       = 0;
    w_gnt_vld = 1'b0;
    w_rot     = NCH'({ch_valid, ch_valid} >> ptr_q);
    for (int off = NCH - 1; off >= 0; off--) begin
      if (w_rot[off]) begin
        w_gnt_vld = 1'b1;
        sum       = int'(ptr_q) + off;
      end
    end
    if (sum >= NCH) begin
      sum = sum - NCH;
    end
    w_gnt_idx = IDX_W'(sum);
  end

  assign ch_ready    = w_gnt_vld ? (NCH'(1) << w_gnt_idx) : '0;
  assign w_cur_depth = ctx_q[w_gnt_idx];
  assign w_cur_bit   = ch_bit[w_gnt_idx];

  seq_match_step #(
    .PAT_W   (PAT_W),
    .PATTERN (PATTERN)
  ) u_step (
    .depth_i      (w_cur_depth),
    .bit_i        (w_cur_bit),
    .next_depth_o (w_next_depth),
    .complete_o   (w_complete)
  );

  always_comb begin
    ptr_d     = ptr_q;
    hit_d     = 1'b0;
    hit_ch_d  = hit_ch_q;
    hit_cnt_d = hit_cnt_q;
    if (w_gnt_vld) begin
      ptr_d = (w_gnt_idx == IDX_W'(NCH - 1)) ? '0 : w_gnt_idx + 1'b1;
      if (w_complete) begin
        hit_d    = 1'b1;
        hit_ch_d = w_gnt_idx;
        if (hit_cnt_q != 8'hFF) begin
          hit_cnt_d = hit_cnt_q + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q     <= '0;
      hit_q     <= 1'b0;
      hit_ch_q  <= '0;
      hit_cnt_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        ctx_q[i] <= '0;
      end
    end else begin
      ptr_q     <= ptr_d;
      hit_q     <= hit_d;
      hit_ch_q  <= hit_ch_d;
      hit_cnt_q <= hit_cnt_d;
      // Only the granted channel's context moves; idle channels keep
      // their partial match indefinitely.
      for (int i = 0; i < NCH; i++) begin
        if (w_gnt_vld && (w_gnt_idx == IDX_W'(i))) begin
          ctx_q[i] <= w_next_depth;
        end
      end
    end
  end

  assign hit     = hit_q;
  assign hit_ch  = hit_ch_q;
  assign hit_cnt = hit_cnt_q;

endmodule
`default_nettype wire
